arm_decode_queue: RTL and testbench
===================================

// Module: arm_decode_queue
// PURPOSE
//  Parametrised successor to the single-register ARM decode stage: a DEPTH-entry queue that decodes each
//  accepted instruction and buffers the decoded record with valid/ready handshakes on both sides.
//  Sits between fetch and execute, absorbing execute stalls and discarding wrong-path work on flush.
//  Adds condition field, multiply class, register-shift detection on bit 4, rotated imm32 and branch offset.
// PARAMETERS
//  DEPTH   4   queue entries, power of two, >=2
//  PC_W    32  width of pc and branch_offset
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      synchronous, active-high
//  flush          in   1      discard all queued entries (branch taken / exception)
//  in_valid       in   1      fetch presents instruction
//  in_ready       out  1      queue can accept (count < DEPTH)
//  instruction    in   32     ARM instruction word
//  in_pc          in   PC_W   address of instruction
//  out_valid      out  1      head record valid
//  out_ready      in   1      execute consumes head
//  cls            out  3      0 DP_REG,1 DP_IMM,2 LS_IMM,3 LS_REG,4 MUL,5 BRANCH,7 UNDEF
//  cond           out  4      instr[31:28]
//  opcode         out  4      instr[24:21] (DP only, else 0)
//  s_bit          out  1      instr[20] for DP/MUL, else 0
//  rd,rn,rm,rs    out  4 ea   register fields (MUL: rd=[19:16], rn=[15:12], rs=[11:8], rm=[3:0])
//  use_rs         out  1      DP_REG with instr[4]=1 (register-specified shift)
//  shift          out  2      instr[6:5] for DP_REG/LS_REG
//  shift_amount   out  5      instr[11:7] when not use_rs, else 0
//  imm32          out  32     DP_IMM: ROR(zext imm8, 2*rot); LS_IMM: zext offset_12; else 0
//  ls_p,ls_u,ls_b,ls_w,ls_l  out 1 ea  instr[24..20] for LS classes, else 0
//  link           out  1      instr[24] for BRANCH
//  branch_offset  out  PC_W   sign-ext(imm24)<<2, truncated to PC_W
//  pc             out  PC_W   pc of head record
//  mem_read       out  1      LS class and ls_l=1
//  mem_write      out  1      LS class and ls_l=0
// BEHAVIOUR
//  - Decode is combinational on instruction; decoded record plus pc written into queue on push.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; in_ready = (count != DEPTH), no bypass.
//  - Latency: record pushed at edge N is visible at head with out_valid=1 after edge N (next cycle) if queue was empty.
//  - Full: in_ready=0; push and pop same cycle when full -> only pop, count DEPTH-1.
//  - Non-full: simultaneous push and pop -> count unchanged, order preserved (FIFO).
//  - Empty: out_valid=0; all record outputs held at 0 when out_valid=0.
//  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
//  - Classification order: cond=1111 -> UNDEF; [27:22]=000000 & [7:4]=1001 -> MUL;
//    [27:25]=000 -> DP_REG; 001 -> DP_IMM; 010 -> LS_IMM; 011 & [4]=0 -> LS_REG; 101 -> BRANCH; else UNDEF.
//  - UNDEF records still queue and dequeue; all fields except cond, pc, cls are 0; mem_read/mem_write 0.
//  - flush: count, read and write pointers -> 0 at the edge; push on that cycle is dropped; out_valid=0 next cycle.
//  - flush and reset both dominate push/pop; reset additionally clears all stored entries.
//  - Reset values: out_valid=0, in_ready=1 after reset deasserts, all record outputs 0.
//  - Reset asserted mid-stream: queue empties at that edge regardless of handshakes.
// TESTING
//  1. push 0xE3A01CFF -> next cycle cls=1, opcode=1101, rd=1, imm32=0x0000FF00, cond=1110, mem_read=0.
//  2. push 0xE5910004 -> cls=2, rn=1, rd=0, imm32=4, ls_p=1, ls_u=1, ls_l=1, mem_read=1, mem_write=0.
//  3. push 0xEAFFFFFE (PC_W=32) -> cls=5, link=0, branch_offset=0xFFFFFFF8; 0xE0000291 -> cls=4, rd=0, rm=1, rs=2.
//  4. DEPTH=4, out_ready=0, push 5 words -> in_ready=0 after 4th; raise out_ready -> 4 records in push order, 5th accepted after first pop.
//  5. queue holds 3 entries, assert flush with in_valid=1 -> next cycle out_valid=0, count=0, flushed-cycle word never appears.
//  6. push 0xF0000000 and 0xE0100010 (LS_REG? no: DP_REG use_rs) -> first cls=7 fields 0; second cls=0, use_rs=1, shift_amount=0.

Source files
------------

// File: rtl/arm_decode_queue.sv
// ARM decode queue: decodes each accepted instruction and buffers the decoded
// record in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
module arm_decode_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      cls,
    output logic [3:0]      cond,
    output logic [3:0]      opcode,
    output logic            s_bit,
    output logic [3:0]      rd,
    output logic [3:0]      rn,
    output logic [3:0]      rm,
    output logic [3:0]      rs,
    output logic            use_rs,
    output logic [1:0]      shift,
    output logic [4:0]      shift_amount,
    output logic [31:0]     imm32,
    output logic            ls_p,
    output logic            ls_u,
    output logic            ls_b,
    output logic            ls_w,
    output logic            ls_l,
    output logic            link,
    output logic [PC_W-1:0] branch_offset,
    output logic [PC_W-1:0] pc,
    output logic            mem_read,
    output logic            mem_write
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [2:0] CLS_DP_REG = 3'd0;
    localparam logic [2:0] CLS_DP_IMM = 3'd1;
    localparam logic [2:0] CLS_LS_IMM = 3'd2;
    localparam logic [2:0] CLS_LS_REG = 3'd3;
    localparam logic [2:0] CLS_MUL    = 3'd4;
    localparam logic [2:0] CLS_BRANCH = 3'd5;
    localparam logic [2:0] CLS_UNDEF  = 3'd7;

    typedef struct packed {
        logic [2:0]      cls;
        logic [3:0]      cond;
        logic [3:0]      opcode;
        logic            s_bit;
        logic [3:0]      rd;
        logic [3:0]      rn;
        logic [3:0]      rm;
        logic [3:0]      rs;
        logic            use_rs;
        logic [1:0]      shift;
        logic [4:0]      shift_amount;
        logic [31:0]     imm32;
        logic            ls_p;
        logic            ls_u;
        logic            ls_b;
        logic            ls_w;
        logic            ls_l;
        logic            link;
        logic [PC_W-1:0] branch_offset;
        logic [PC_W-1:0] pc;
        logic            mem_read;
        logic            mem_write;
    } rec_t;

    rec_t              dec;
    rec_t              head;
    rec_t              mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;
    logic [31:0]       imm8_z;
    logic [4:0]        rot;
    logic [31:0]       imm_ror;
    logic signed [31:0] br_off32;
    logic              is_mul;

    // Combinational decode of the instruction presented by fetch
    always_comb begin
        dec      = '0;
        imm8_z   = 32'(instruction[7:0]);
        rot      = {instruction[11:8], 1'b0};
        imm_ror  = (imm8_z >> rot) | (imm8_z << (6'd32 - {1'b0, rot}));
        br_off32 = {{6{instruction[23]}}, instruction[23:0], 2'b00};
        is_mul   = (instruction[27:22] == 6'b000000) && (instruction[7:4] == 4'b1001);

        dec.cond = instruction[31:28];
        dec.pc   = in_pc;

        if (instruction[31:28] == 4'hF) begin
            dec.cls = CLS_UNDEF;
        end else if (is_mul) begin
            dec.cls   = CLS_MUL;
            dec.s_bit = instruction[20];
            dec.rd    = instruction[19:16];
            dec.rn    = instruction[15:12];
            dec.rs    = instruction[11:8];
            dec.rm    = instruction[3:0];
        end else begin
            case (instruction[27:25])
                3'b000: begin
                    dec.cls    = CLS_DP_REG;
                    dec.opcode = instruction[24:21];
                    dec.s_bit  = instruction[20];
                    dec.rn     = instruction[19:16];
                    dec.rd     = instruction[15:12];
                    dec.rm     = instruction[3:0];
                    dec.use_rs = instruction[4];
                    dec.shift  = instruction[6:5];
                    if (instruction[4]) begin
                        dec.rs = instruction[11:8];
                    end else begin
                        dec.shift_amount = instruction[11:7];
                    end
                end
                3'b001: begin
                    dec.cls    = CLS_DP_IMM;
                    dec.opcode = instruction[24:21];
                    dec.s_bit  = instruction[20];
                    dec.rn     = instruction[19:16];
                    dec.rd     = instruction[15:12];
                    dec.imm32  = imm_ror;
                end
                3'b010, 3'b011: begin
                    // Register-offset load/store with bit 4 set is not a valid LS form
                    if (instruction[25] && instruction[4]) begin
                        dec.cls = CLS_UNDEF;
                    end else begin
                        dec.cls       = instruction[25] ? CLS_LS_REG : CLS_LS_IMM;
                        dec.rn        = instruction[19:16];
                        dec.rd        = instruction[15:12];
                        dec.ls_p      = instruction[24];
                        dec.ls_u      = instruction[23];
                        dec.ls_b      = instruction[22];
                        dec.ls_w      = instruction[21];
                        dec.ls_l      = instruction[20];
                        dec.mem_read  = instruction[20];
                        dec.mem_write = ~instruction[20];
                        if (instruction[25]) begin
                            dec.rm           = instruction[3:0];
                            dec.shift        = instruction[6:5];
                            dec.shift_amount = instruction[11:7];
                        end else begin
                            dec.imm32 = 32'(instruction[11:0]);
                        end
                    end
                end
                3'b101: begin
                    dec.cls           = CLS_BRANCH;
                    dec.link          = instruction[24];
                    dec.branch_offset = PC_W'(br_off32);
                end
                default: dec.cls = CLS_UNDEF;
            endcase
        end
    end

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    // Queue storage, pointers and occupancy; reset and flush dominate handshakes
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Head record, forced to zero while the queue is empty
    assign head = out_valid ? mem[rd_ptr] : '0;

    assign cls           = head.cls;
    assign cond          = head.cond;
    assign opcode        = head.opcode;
    assign s_bit         = head.s_bit;
    assign rd            = head.rd;
    assign rn            = head.rn;
    assign rm            = head.rm;
    assign rs            = head.rs;
    assign use_rs        = head.use_rs;
    assign shift         = head.shift;
    assign shift_amount  = head.shift_amount;
    assign imm32         = head.imm32;
    assign ls_p          = head.ls_p;
    assign ls_u          = head.ls_u;
    assign ls_b          = head.ls_b;
    assign ls_w          = head.ls_w;
    assign ls_l          = head.ls_l;
    assign link          = head.link;
    assign branch_offset = head.branch_offset;
    assign pc            = head.pc;
    assign mem_read      = head.mem_read;
    assign mem_write     = head.mem_write;

endmodule

// File: tb/tb_arm_decode_queue.sv
// Scoreboard bench for arm_decode_queue: directed decode cases, backpressure,
// flush, mid-stream reset and a randomised back-to-back stream.
module tb_arm_decode_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PC_W  = 32;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, out_ready;
    logic            in_ready, out_valid;
    logic [31:0]     instruction;
    logic [PC_W-1:0] in_pc;
    logic [2:0]      cls;
    logic [3:0]      cond, opcode, rd, rn, rm, rs;
    logic            s_bit, use_rs, ls_p, ls_u, ls_b, ls_w, ls_l, link, mem_read, mem_write;
    logic [1:0]      shift;
    logic [4:0]      shift_amount;
    logic [31:0]     imm32;
    logic [PC_W-1:0] branch_offset, pc;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0]      cls;
        logic [3:0]      cond;
        logic [3:0]      opcode;
        logic            s_bit;
        logic [3:0]      rd;
        logic [3:0]      rn;
        logic [3:0]      rm;
        logic [3:0]      rs;
        logic            use_rs;
        logic [1:0]      shift;
        logic [4:0]      shift_amount;
        logic [31:0]     imm32;
        logic            ls_p;
        logic            ls_u;
        logic            ls_b;
        logic            ls_w;
        logic            ls_l;
        logic            link;
        logic [PC_W-1:0] branch_offset;
        logic [PC_W-1:0] pc;
        logic            mem_read;
        logic            mem_write;
    } rec_t;

    rec_t exp_q[$];

    arm_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .cls(cls), .cond(cond), .opcode(opcode), .s_bit(s_bit),
        .rd(rd), .rn(rn), .rm(rm), .rs(rs), .use_rs(use_rs),
        .shift(shift), .shift_amount(shift_amount), .imm32(imm32),
        .ls_p(ls_p), .ls_u(ls_u), .ls_b(ls_b), .ls_w(ls_w), .ls_l(ls_l),
        .link(link), .branch_offset(branch_offset), .pc(pc),
        .mem_read(mem_read), .mem_write(mem_write)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic rec_t obs();
        rec_t r;
        r.cls = cls; r.cond = cond; r.opcode = opcode; r.s_bit = s_bit;
        r.rd = rd; r.rn = rn; r.rm = rm; r.rs = rs; r.use_rs = use_rs;
        r.shift = shift; r.shift_amount = shift_amount; r.imm32 = imm32;
        r.ls_p = ls_p; r.ls_u = ls_u; r.ls_b = ls_b; r.ls_w = ls_w; r.ls_l = ls_l;
        r.link = link; r.branch_offset = branch_offset; r.pc = pc;
        r.mem_read = mem_read; r.mem_write = mem_write;
        return r;
    endfunction

    // Reference decoder: rotation done bit by bit, branch offset by multiplication
    function automatic rec_t model(input logic [31:0] w, input logic [PC_W-1:0] p);
        rec_t r = '0;
        logic [31:0] v;
        logic signed [31:0] off;
        r.cond = w[31:28];
        r.pc   = p;
        if (w[31:28] == 4'hF) begin
            r.cls = 3'd7;
        end else if (w[27:22] == 6'd0 && w[7:4] == 4'b1001) begin
            r.cls = 3'd4; r.s_bit = w[20];
            r.rd = w[19:16]; r.rn = w[15:12]; r.rs = w[11:8]; r.rm = w[3:0];
        end else if (w[27:25] == 3'b000) begin
            r.cls = 3'd0; r.opcode = w[24:21]; r.s_bit = w[20];
            r.rn = w[19:16]; r.rd = w[15:12]; r.rm = w[3:0]; r.shift = w[6:5];
            r.use_rs = w[4];
            r.rs = w[4] ? w[11:8] : 4'd0;
            r.shift_amount = w[4] ? 5'd0 : w[11:7];
        end else if (w[27:25] == 3'b001) begin
            r.cls = 3'd1; r.opcode = w[24:21]; r.s_bit = w[20];
            r.rn = w[19:16]; r.rd = w[15:12];
            v = {24'd0, w[7:0]};
            for (int k = 0; k < 2 * int'(w[11:8]); k++) v = {v[0], v[31:1]};
            r.imm32 = v;
        end else if (w[27:25] == 3'b010 || (w[27:25] == 3'b011 && !w[4])) begin
            r.cls = w[25] ? 3'd3 : 3'd2;
            r.rn = w[19:16]; r.rd = w[15:12];
            {r.ls_p, r.ls_u, r.ls_b, r.ls_w, r.ls_l} = w[24:20];
            r.mem_read = w[20]; r.mem_write = !w[20];
            if (w[25]) begin
                r.rm = w[3:0]; r.shift = w[6:5]; r.shift_amount = w[11:7];
            end else begin
                r.imm32 = {20'd0, w[11:0]};
            end
        end else if (w[27:25] == 3'b101) begin
            r.cls = 3'd5; r.link = w[24];
            off = $signed({{8{w[23]}}, w[23:0]}) * 4;
            r.branch_offset = PC_W'(off);
        end else begin
            r.cls = 3'd7;
        end
        return r;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 5))
            0: return r;
            1: return {4'hE, 6'd0, r[21:8], 4'b1001, r[3:0]};
            2: return {4'hE, 3'b000, r[24:0]};
            3: return {4'hE, 3'b001, r[24:0]};
            4: return {4'hE, 2'b01, r[25:0]};
            default: return {4'hE, 3'b101, r[24:0]};
        endcase
    endfunction

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        instruction = 32'hE3A01CFF; in_pc = 32'h40;
        tick; tick;
        reset = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        total++; if (obs() !== rec_t'(0)) begin bad++; $display("FAIL rst_record got=%h want=0", obs()); end
    endtask

    task automatic test_dp_imm_ls_imm;
        rec_t e;
        out_ready = 1'b0; in_valid = 1'b1;
        instruction = 32'hE3A01CFF; in_pc = 32'h100;
        exp_q.push_back(model(instruction, in_pc));
        tick;
        instruction = 32'hE5910004; in_pc = 32'h104;
        exp_q.push_back(model(instruction, in_pc));
        tick;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dpi_valid got=%b want=1", out_valid); end
        total++; if (cls !== 3'd1 || opcode !== 4'b1101 || rd !== 4'd1 || cond !== 4'hE)
            begin bad++; $display("FAIL dpi_fields got cls=%0d op=%b rd=%0d cond=%h want 1/1101/1/e", cls, opcode, rd, cond); end
        total++; if (imm32 !== 32'h0000FF00 || mem_read !== 1'b0)
            begin bad++; $display("FAIL dpi_imm got imm=%h mr=%b want 0000ff00/0", imm32, mem_read); end
        e = exp_q.pop_front();
        total++; if (obs() !== e) begin bad++; $display("FAIL dpi_sb got=%h want=%h", obs(), e); end
        out_ready = 1'b1; tick; out_ready = 1'b0;
        total++; if (cls !== 3'd2 || rn !== 4'd1 || rd !== 4'd0 || imm32 !== 32'd4)
            begin bad++; $display("FAIL lsi_fields got cls=%0d rn=%0d rd=%0d imm=%h want 2/1/0/4", cls, rn, rd, imm32); end
        total++; if ({ls_p, ls_u, ls_l, mem_read, mem_write} !== 5'b11110)
            begin bad++; $display("FAIL lsi_bits got=%b want=11110", {ls_p, ls_u, ls_l, mem_read, mem_write}); end
        e = exp_q.pop_front();
        total++; if (obs() !== e) begin bad++; $display("FAIL lsi_sb got=%h want=%h", obs(), e); end
        out_ready = 1'b1; tick; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lsi_empty got=%b want=0", out_valid); end
    endtask

    task automatic test_branch_mul;
        rec_t e;
        out_ready = 1'b0; in_valid = 1'b1;
        instruction = 32'hEAFFFFFE; in_pc = 32'h200;
        exp_q.push_back(model(instruction, in_pc));
        tick;
        instruction = 32'hE0000291; in_pc = 32'h204;
        exp_q.push_back(model(instruction, in_pc));
        tick;
        in_valid = 1'b0;
        total++; if (cls !== 3'd5 || link !== 1'b0 || branch_offset !== 32'hFFFFFFF8 || pc !== 32'h200)
            begin bad++; $display("FAIL br_fields got cls=%0d l=%b off=%h pc=%h want 5/0/fffffff8/200", cls, link, branch_offset, pc); end
        e = exp_q.pop_front();
        total++; if (obs() !== e) begin bad++; $display("FAIL br_sb got=%h want=%h", obs(), e); end
        out_ready = 1'b1; tick; out_ready = 1'b0;
        total++; if (cls !== 3'd4 || rd !== 4'd0 || rm !== 4'd1 || rs !== 4'd2)
            begin bad++; $display("FAIL mul_fields got cls=%0d rd=%0d rm=%0d rs=%0d want 4/0/1/2", cls, rd, rm, rs); end
        e = exp_q.pop_front();
        total++; if (obs() !== e) begin bad++; $display("FAIL mul_sb got=%h want=%h", obs(), e); end
        out_ready = 1'b1; tick; out_ready = 1'b0;
    endtask

    task automatic test_undef_use_rs;
        rec_t e;
        out_ready = 1'b0; in_valid = 1'b1;
        instruction = 32'hF0000000; in_pc = 32'h300;
        exp_q.push_back(model(instruction, in_pc));
        tick;
        instruction = 32'hE0100010; in_pc = 32'h304;
        exp_q.push_back(model(instruction, in_pc));
        tick;
        in_valid = 1'b0;
        e = '0; e.cls = 3'd7; e.cond = 4'hF; e.pc = 32'h300;
        total++; if (obs() !== e) begin bad++; $display("FAIL undef_rec got=%h want=%h", obs(), e); end
        e = exp_q.pop_front();
        total++; if (obs() !== e) begin bad++; $display("FAIL undef_sb got=%h want=%h", obs(), e); end
        out_ready = 1'b1; tick; out_ready = 1'b0;
        total++; if (cls !== 3'd0 || use_rs !== 1'b1 || shift_amount !== 5'd0)
            begin bad++; $display("FAIL rs_fields got cls=%0d use_rs=%b sa=%0d want 0/1/0", cls, use_rs, shift_amount); end
        e = exp_q.pop_front();
        total++; if (obs() !== e) begin bad++; $display("FAIL rs_sb got=%h want=%h", obs(), e); end
        out_ready = 1'b1; tick; out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        rec_t e;
        logic [31:0] words [5];
        int budget;
        words[0] = 32'hE3A01001; words[1] = 32'hE5912008; words[2] = 32'hEB000010;
        words[3] = 32'hE0010392; words[4] = 32'hE7910102;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            instruction = words[i]; in_pc = 32'h400 + 32'(4 * i); in_valid = 1'b1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready%0d got=%b want=1", i, in_ready); end
            exp_q.push_back(model(instruction, in_pc));
            tick;
        end
        instruction = words[4]; in_pc = 32'h410;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b want=0", in_ready); end
        tick;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_hold got=%b want=0", in_ready); end
        out_ready = 1'b1;
        e = exp_q.pop_front();
        total++; if (obs() !== e) begin bad++; $display("FAIL bp_first got=%h want=%h", obs(), e); end
        tick;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_reopen got=%b want=1", in_ready); end
        exp_q.push_back(model(instruction, in_pc));
        e = exp_q.pop_front();
        total++; if (obs() !== e) begin bad++; $display("FAIL bp_second got=%h want=%h", obs(), e); end
        tick;
        in_valid = 1'b0;
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                total++; if (obs() !== e) begin bad++; $display("FAIL bp_drain got=%h want=%h", obs(), e); end
            end
            tick; budget--;
        end
        total++; if (exp_q.size() != 0 || out_valid !== 1'b0)
            begin bad++; $display("FAIL bp_end left=%0d out_valid=%b want 0/0", exp_q.size(), out_valid); end
        exp_q.delete();
        out_ready = 1'b0;
    endtask

    task automatic test_flush;
        rec_t e;
        int budget;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instruction = 32'hE2800001 + 32'(i); in_pc = 32'h500 + 32'(4 * i);
            tick;
        end
        flush = 1'b1; instruction = 32'hE1A00000; in_pc = 32'h50C;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_ready got=%b want=1", in_ready); end
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instruction = 32'hE5810000 + 32'(i); in_pc = 32'h600 + 32'(4 * i);
            exp_q.push_back(model(instruction, in_pc));
            tick;
        end
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_count got in_ready=%b want=0", in_ready); end
        out_ready = 1'b1;
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                total++; if (obs() !== e) begin bad++; $display("FAIL fl_order got=%h want=%h", obs(), e); end
            end
            tick; budget--;
        end
        total++; if (exp_q.size() != 0 || out_valid !== 1'b0)
            begin bad++; $display("FAIL fl_end left=%0d out_valid=%b want 0/0", exp_q.size(), out_valid); end
        exp_q.delete();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        rec_t e;
        int budget;
        for (int c = 0; c < 400; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            instruction = gen();
            in_pc       = 32'h1000 + 32'(4 * c);
            total++; if (out_valid !== (exp_q.size() != 0))
                begin bad++; $display("FAIL b2b_valid c=%0d got=%b want=%b", c, out_valid, exp_q.size() != 0); end
            total++; if (in_ready !== (exp_q.size() != DEPTH))
                begin bad++; $display("FAIL b2b_ready c=%0d got=%b want=%b", c, in_ready, exp_q.size() != DEPTH); end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++; if (obs() !== e) begin bad++; $display("FAIL b2b_rec c=%0d got=%h want=%h", c, obs(), e); end
            end
            if (in_valid && in_ready) exp_q.push_back(model(instruction, in_pc));
            tick;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                total++; if (obs() !== e) begin bad++; $display("FAIL b2b_drain got=%h want=%h", obs(), e); end
            end
            tick; budget--;
        end
        total++; if (exp_q.size() != 0 || out_valid !== 1'b0)
            begin bad++; $display("FAIL b2b_end left=%0d out_valid=%b want 0/0", exp_q.size(), out_valid); end
        exp_q.delete();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        in_valid = 1'b1; out_ready = 1'b0;
        instruction = 32'hE3A02005; in_pc = 32'h700; tick;
        instruction = 32'hE3A03006; in_pc = 32'h704; tick;
        reset = 1'b1; out_ready = 1'b1; instruction = 32'hE3A04007; in_pc = 32'h708;
        tick;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", out_valid); end
        total++; if (obs() !== rec_t'(0)) begin bad++; $display("FAIL rmid_record got=%h want=0", obs()); end
        tick;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL rmid_idle got v=%b r=%b want 0/1", out_valid, in_ready); end
    endtask

    initial begin
        test_reset;
        test_dp_imm_ls_imm;
        test_branch_mul;
        test_undef_use_rs;
        test_backpressure;
        test_flush;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
